retire_trace_monitor: RTL and testbench
=======================================

Name: retire_trace_monitor

Overview:
Synthesizable commit-trace monitor for the pipelined RISC-V core. It sits beside the CPU top and watches the WB-stage retirement port and the DM store-commit port. It buffers per-instruction trace records in a parametrised FIFO drained over a valid/ready stream. It also counts cycles and retirements, and ends the run on a tohost store (PASS/FAIL) or on a cycle-limit watchdog (TIMEOUT).

Parameters:
XLEN, 32, datapath width of pc, wdata, store address and store data
DEPTH, 16, trace FIFO entries; power of two, minimum 2
MAX_CYCLES, 200, watchdog limit in clock cycles; 0 disables the watchdog
TOHOST_ADDR, 32'h0000_0400, store address that ends the run
SKIP_PC0, 1, when 1, a retirement with ret_pc == 0 is a bubble and is ignored

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
ret_valid  in  1  one instruction retires this cycle
ret_pc  in  XLEN  pc of the retiring instruction
ret_we  in  1  retiring instruction writes rd
ret_rd  in  5  destination register index
ret_wdata  in  XLEN  value written to rd
st_valid  in  1  store commits to DM this cycle
st_addr  in  XLEN  store byte address
st_data  in  XLEN  store data
tr_valid  out  1  trace record available
tr_ready  in  1  consumer accepts the record
tr_pc  out  XLEN  record pc
tr_we  out  1  record write-enable; ret_we && (ret_rd != 0)
tr_rd  out  5  record rd
tr_wdata  out  XLEN  record wdata
tr_seq  out  32  record sequence number
cycle_count  out  32  cycles counted since reset, state RUN only
retired_count  out  32  non-bubble retirements
status  out  2  0 RUN, 1 PASS, 2 FAIL, 3 TIMEOUT
fail_code  out  XLEN-1  st_data >> 1 latched on FAIL
overflow  out  1  sticky; a record was dropped because the FIFO was full
done  out  1  status != RUN and FIFO empty

Behaviour:
- Reset (reset == 0 at a rising edge):
  - All counters, status, fail_code, overflow, done, tr_valid and FIFO pointers go to 0.
  - tr_* data outputs go to 0.
  - Reset applied mid-run discards buffered records.
- Capture:
  - A cycle captures when status == RUN, ret_valid = 1, and not (SKIP_PC0 && ret_pc == 0).
  - retired_count increments on every capture.
  - The record's tr_seq equals the retired_count value before the increment, so the first record is 0.
  - Gaps in tr_seq identify dropped records.
- FIFO:
  - Registered, show-ahead.
  - A record pushed into an empty FIFO appears with tr_valid = 1 on the next cycle (latency 1). There is no same-cycle bypass.
  - A pop happens when tr_valid && tr_ready.
  - tr_* outputs hold stable while tr_valid && !tr_ready.
- Boundary conditions:
  - Full FIFO with a push and a pop in the same cycle: both occur, the record is kept, occupancy is unchanged.
  - Full FIFO with a push and no pop: the record is dropped, overflow is set to 1, retired_count still increments.
  - Pointers wrap modulo DEPTH.
  - All 32-bit counters wrap modulo 2^32.
- State machine (status):
  - RUN -> PASS: st_valid && st_addr == TOHOST_ADDR && st_data == 1.
  - RUN -> FAIL: same address match, st_data odd and != 1. fail_code latches st_data >> 1.
  - An even st_data to TOHOST_ADDR is ignored.
  - RUN -> TIMEOUT: MAX_CYCLES != 0 and cycle_count == MAX_CYCLES - 1 at the edge. cycle_count reaches MAX_CYCLES and freezes.
  - PASS, FAIL and TIMEOUT are terminal until reset.
  - In a terminal state, capture and cycle counting stop; the FIFO keeps draining.
- Simultaneous events:
  - A tohost store and the watchdog expiring in the same cycle: the store wins (PASS or FAIL).
  - A retirement in the same cycle as the terminating store is still captured.
- done is registered. It rises the cycle after the final pop, or the cycle after termination if the FIFO is already empty.

Test Plan:
- Reset, then 5 retirements (pc 0x4..0x14) with tr_ready = 1 -> 5 records; tr_seq 0..4; each record appears 1 cycle after capture; retired_count = 5.
- SKIP_PC0 = 1: retirements at pc 0x0, 0x8, 0x0, 0xC -> 2 records (0x8, 0xC), tr_seq 0 and 1; retired_count = 2.
- DEPTH = 4, tr_ready = 0, 6 retirements -> 4 records held, overflow = 1, retired_count = 6. Then tr_ready = 1 -> records drain with tr_seq 0..3.
- Store to TOHOST_ADDR: data 0x1 -> PASS. Separate run with data 0x7 -> FAIL, fail_code = 3. Separate run with data 0x2 -> status stays RUN.
- MAX_CYCLES = 200, no tohost store -> status = TIMEOUT at the edge where cycle_count reaches 200; cycle_count holds at 200; no captures afterwards; done = 1 once the FIFO drains.
- Tohost store (data 1) in the same cycle as watchdog expiry, with reset = 0 applied 3 cycles later mid-drain -> status = PASS, not TIMEOUT; after the reset, all outputs are 0 and tr_valid = 0.

Source files
------------

// File: rtl/retire_trace_monitor.sv
// Commit-trace monitor: captures WB retirements into a show-ahead trace FIFO,
// counts cycles/retirements and ends the run on a tohost store or watchdog.
//
// state   | meaning
// RUN     | capturing retirements and counting cycles
// PASS    | tohost store of 1 seen
// FAIL    | tohost store of an odd value other than 1; fail_code holds value >> 1
// TIMEOUT | watchdog reached MAX_CYCLES without a tohost store
module retire_trace_monitor #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH       = 16,
  parameter int unsigned     MAX_CYCLES  = 200,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 'h400,
  parameter bit              SKIP_PC0    = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ret_valid,
  input  logic [XLEN-1:0] ret_pc,
  input  logic            ret_we,
  input  logic [4:0]      ret_rd,
  input  logic [XLEN-1:0] ret_wdata,
  input  logic            st_valid,
  input  logic [XLEN-1:0] st_addr,
  input  logic [XLEN-1:0] st_data,
  output logic            tr_valid,
  input  logic            tr_ready,
  output logic [XLEN-1:0] tr_pc,
  output logic            tr_we,
  output logic [4:0]      tr_rd,
  output logic [XLEN-1:0] tr_wdata,
  output logic [31:0]     tr_seq,
  output logic [31:0]     cycle_count,
  output logic [31:0]     retired_count,
  output logic [1:0]      status,
  output logic [XLEN-2:0] fail_code,
  output logic            overflow,
  output logic            done
);

  localparam int unsigned AW       = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int unsigned RW       = 2 * XLEN + 38;
  localparam logic [31:0] CYC_LAST = 32'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t status_q, status_d;

  logic [RW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [RW-1:0] rec_in, rec_out;
  logic          running, capture, push, pop, empty, full;
  logic          tohost_hit, wd_expire;

  assign running    = (status_q == ST_RUN);
  assign capture    = running && ret_valid && !(SKIP_PC0 && (ret_pc == '0));
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tr_valid   = !empty;
  assign pop        = tr_valid && tr_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push       = capture && (!full || pop);
  assign tohost_hit = st_valid && (st_addr == TOHOST_ADDR) && st_data[0];
  assign wd_expire  = (MAX_CYCLES != 0) && (cycle_count == CYC_LAST);

  assign rec_in  = {ret_pc, ret_we && (ret_rd != 5'd0), ret_rd, ret_wdata, retired_count};
  assign rec_out = mem[rd_ptr[AW-1:0]];

  // Masking keeps the record outputs at zero whenever nothing is buffered.
  assign tr_seq   = tr_valid ? rec_out[31:0]                : '0;
  assign tr_wdata = tr_valid ? rec_out[XLEN+31:32]          : '0;
  assign tr_rd    = tr_valid ? rec_out[XLEN+36:XLEN+32]     : '0;
  assign tr_we    = tr_valid ? rec_out[XLEN+37]             : 1'b0;
  assign tr_pc    = tr_valid ? rec_out[2*XLEN+37:XLEN+38]   : '0;

  assign status = status_q;

  always_comb begin
    status_d = status_q;
    if (status_q == ST_RUN) begin
      if (tohost_hit) begin
        status_d = (st_data == XLEN'(1)) ? ST_PASS : ST_FAIL;
      end else if (wd_expire) begin
        status_d = ST_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      status_q      <= ST_RUN;
      cycle_count   <= '0;
      retired_count <= '0;
      fail_code     <= '0;
      overflow      <= 1'b0;
      done          <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
    end else begin
      status_q <= status_d;
      if (running) cycle_count <= cycle_count + 32'd1;
      if (capture) retired_count <= retired_count + 32'd1;
      if (running && status_d == ST_FAIL) fail_code <= st_data[XLEN-1:1];
      if (capture && full && !pop) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      done <= !running && empty;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rec_in;
  end

endmodule

// File: tb/tb_retire_trace_monitor.sv
// Directed bench for retire_trace_monitor: capture, bubble skip, overflow,
// tohost PASS/FAIL, watchdog timeout and store-vs-watchdog priority.
module tb_retire_trace_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        ret_valid, ret_we, st_valid, tr_ready;
  logic [31:0] ret_pc, ret_wdata, st_addr, st_data;
  logic [4:0]  ret_rd;
  logic        tr_valid, tr_we, overflow, done;
  logic [31:0] tr_pc, tr_wdata, tr_seq, cycle_count, retired_count;
  logic [4:0]  tr_rd;
  logic [1:0]  status;
  logic [30:0] fail_code;

  int n_checks = 0;
  int n_errors = 0;

  retire_trace_monitor #(
    .XLEN(32), .DEPTH(4), .MAX_CYCLES(200), .TOHOST_ADDR(32'h400), .SKIP_PC0(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_we(ret_we), .ret_rd(ret_rd),
    .ret_wdata(ret_wdata), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_pc(tr_pc), .tr_we(tr_we),
    .tr_rd(tr_rd), .tr_wdata(tr_wdata), .tr_seq(tr_seq),
    .cycle_count(cycle_count), .retired_count(retired_count), .status(status),
    .fail_code(fail_code), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ret_valid = 0; ret_pc = 0; ret_we = 0; ret_rd = 0; ret_wdata = 0;
    st_valid = 0; st_addr = 0; st_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    tr_ready = 0;
    reset = 0;
    tick();
    tick();
    reset = 1;
  endtask

  task automatic retire(input logic [31:0] pc, input logic we, input logic [4:0] rd,
                        input logic [31:0] wd);
    ret_valid = 1; ret_pc = pc; ret_we = we; ret_rd = rd; ret_wdata = wd;
  endtask

  task automatic tohost(input logic [31:0] data);
    st_valid = 1; st_addr = 32'h400; st_data = data;
  endtask

  initial begin
    do_reset();
    chk("rst_status", status, 0);
    chk("rst_valid", tr_valid, 0);
    chk("rst_cycles", cycle_count, 0);
    chk("rst_retired", retired_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_done", done, 0);

    // five retirements drained immediately; rd=0 on the third clears tr_we
    tr_ready = 1;
    for (int i = 0; i < 5; i++) begin
      retire(32'(4 * (i + 1)), 1'b1, (i == 2) ? 5'd0 : 5'(i + 1), 32'(32'hA0 + i));
      chk("t1_valid_pre", tr_valid, (i == 0) ? 0 : 1);
      tick();
      chk("t1_valid", tr_valid, 1);
      chk("t1_pc", tr_pc, 4 * (i + 1));
      chk("t1_seq", tr_seq, i);
      chk("t1_we", tr_we, (i == 2) ? 0 : 1);
      chk("t1_rd", tr_rd, (i == 2) ? 0 : i + 1);
      chk("t1_wdata", tr_wdata, 32'hA0 + i);
    end
    idle_inputs();
    tick();
    chk("t1_empty", tr_valid, 0);
    chk("t1_retired", retired_count, 5);
    chk("t1_cycles", cycle_count, 6);

    // bubbles at pc 0 are skipped
    do_reset();
    tr_ready = 1;
    retire(32'h0, 1, 1, 1); tick();
    chk("t2_bubble0", tr_valid, 0);
    retire(32'h8, 1, 1, 1); tick();
    chk("t2_pc8", tr_pc, 32'h8);
    chk("t2_seq0", tr_seq, 0);
    retire(32'h0, 1, 1, 1); tick();
    chk("t2_bubble1", tr_valid, 0);
    retire(32'hC, 1, 1, 1); tick();
    chk("t2_pcC", tr_pc, 32'hC);
    chk("t2_seq1", tr_seq, 1);
    idle_inputs(); tick();
    chk("t2_retired", retired_count, 2);

    // overflow with a stalled consumer
    do_reset();
    for (int i = 0; i < 6; i++) begin
      retire(32'(4 * (i + 1)), 1, 1, 0);
      tick();
      chk("t3_ovf_prog", overflow, (i >= 4) ? 1 : 0);
    end
    idle_inputs();
    tick();
    chk("t3_overflow", overflow, 1);
    chk("t3_retired", retired_count, 6);
    chk("t3_hold_pc", tr_pc, 4);
    tick();
    chk("t3_hold_pc2", tr_pc, 4);
    tr_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk("t3_drain_valid", tr_valid, 1);
      chk("t3_drain_pc", tr_pc, 4 * (k + 1));
      chk("t3_drain_seq", tr_seq, k);
      tick();
    end
    chk("t3_drained", tr_valid, 0);

    // full FIFO with simultaneous push and pop keeps the record
    do_reset();
    for (int i = 0; i < 4; i++) begin
      retire(32'(16 * (i + 1)), 1, 1, 0);
      tick();
    end
    retire(32'h50, 1, 1, 0);
    tr_ready = 1;
    tick();
    idle_inputs();
    chk("t3b_overflow", overflow, 0);
    for (int k = 0; k < 4; k++) begin
      chk("t3b_pc", tr_pc, 16 * (k + 2));
      chk("t3b_seq", tr_seq, k + 1);
      tick();
    end
    chk("t3b_empty", tr_valid, 0);

    // tohost PASS, FAIL and ignored even value
    do_reset();
    tohost(32'h1); tick(); idle_inputs();
    chk("t4_pass", status, 1);
    chk("t4_done_early", done, 0);
    tick();
    chk("t4_done", done, 1);
    chk("t4_cycles_frozen", cycle_count, 1);
    do_reset();
    tohost(32'h7); tick(); idle_inputs();
    chk("t4_fail", status, 2);
    chk("t4_fail_code", fail_code, 3);
    do_reset();
    tohost(32'h2); tick(); idle_inputs();
    tick();
    chk("t4_even", status, 0);
    chk("t4_even_done", done, 0);

    // watchdog timeout
    do_reset();
    retire(32'h40, 1, 2, 32'h55); tick(); idle_inputs();
    repeat (198) tick();
    chk("t5_cycles199", cycle_count, 199);
    chk("t5_run", status, 0);
    tick();
    chk("t5_timeout", status, 3);
    chk("t5_cycles200", cycle_count, 200);
    retire(32'h50, 1, 2, 0); tick(); idle_inputs();
    chk("t5_no_capture", retired_count, 1);
    chk("t5_frozen", cycle_count, 200);
    chk("t5_head", tr_pc, 32'h40);
    chk("t5_not_done", done, 0);
    tr_ready = 1; tick();
    chk("t5_popped", tr_valid, 0);
    chk("t5_done_lag", done, 0);
    tick();
    chk("t5_done", done, 1);

    // store and watchdog expiry together; reset mid-drain
    do_reset();
    repeat (198) tick();
    retire(32'h5C, 1, 3, 0); tick();
    chk("t6_cycles199", cycle_count, 199);
    retire(32'h60, 1, 3, 0); tohost(32'h1); tick(); idle_inputs();
    chk("t6_pass", status, 1);
    chk("t6_cycles", cycle_count, 200);
    chk("t6_retired", retired_count, 2);
    tick(); tick();
    chk("t6_pending", tr_valid, 1);
    reset = 0; tick(); reset = 1;
    chk("t6_rst_valid", tr_valid, 0);
    chk("t6_rst_status", status, 0);
    chk("t6_rst_cycles", cycle_count, 0);
    chk("t6_rst_retired", retired_count, 0);
    chk("t6_rst_pc", tr_pc, 0);
    chk("t6_rst_seq", tr_seq, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_fail", fail_code, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
